// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready adder among N_REQ requesters.
// Optional: define ADDER_RR_ARB_PRIO0_EN to give requester 0 strict priority.
module adder_rr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       rsp_sum,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  output logic                    add_valid,
  input  logic                    add_ready,
  input  logic [DATA_W-1:0]       add_sum,
  input  logic                    add_out_valid,
  output logic                    add_out_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   sum_q, sum_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [DATA_W-1:0]   win_a, win_b;
  logic                rsp_ack;
  logic [ID_W-1:0]     rr_next;

  // Winner search: first valid at or above rr_ptr, else lowest valid (wrap).
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef ADDER_RR_ARB_PRIO0_EN
    if (req_valid[0]) begin
      found = 1'b1;
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end

  // Operand select for the winner and response-accept select for the owner.
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    rsp_ack = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_a = req_a[i*DATA_W +: DATA_W];
        win_b = req_b[i*DATA_W +: DATA_W];
      end
      if (grant_q == ID_W'(i)) begin
        rsp_ack = rsp_ready[i];
      end
    end
  end

  assign rr_next = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = win_a;
          b_d     = win_b;
          grant_d = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (add_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (add_out_valid) begin
          sum_d   = add_sum;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ack) begin
          state_d = IDLE;
`ifdef ADDER_RR_ARB_PRIO0_EN
          if (grant_q != '0) rr_ptr_d = rr_next;
`else
          rr_ptr_d = rr_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

  // Per-requester strobes; req_ready is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = !rst && (state_q == IDLE) && found && (win == ID_W'(i));
      rsp_valid[i] = (state_q == RESP) && (grant_q == ID_W'(i));
    end
  end

  assign add_a         = a_q;
  assign add_b         = b_q;
  assign add_valid     = (state_q == ISSUE);
  assign add_out_ready = (state_q == WAIT_RES);
  assign rsp_sum       = sum_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter with a one-deep behavioural adder.
module tb_adder_rr_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
  } rsp_t;

  logic          clk;
  logic          rst;
  logic [127:0]  req_a, req_b;
  logic [3:0]    req_valid, req_ready;
  logic [31:0]   rsp_sum;
  logic [3:0]    rsp_valid, rsp_ready;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_valid, add_ready, add_out_valid, add_out_ready;
  logic [1:0]    grant_id;
  logic          busy;

  logic [31:0]   a_arr [4];
  logic [31:0]   b_arr [4];
  logic [3:0]    oneshot;
  logic          add_rdy_en;
  logic          out_v;
  logic [31:0]   out_sum;

  rsp_t          exp_q [$];
  rsp_t          got_q [$];
  int            grants [$];
  int            n_checks, n_pass, viol;

  adder_rr_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_sum(rsp_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_ready(add_ready),
    .add_sum(add_sum), .add_out_valid(add_out_valid), .add_out_ready(add_out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = a_arr[i];
      req_b[i*32 +: 32] = b_arr[i];
    end
  end

  // Behavioural adder: one operation in flight, result one cycle after issue.
  assign add_ready     = add_rdy_en && !out_v;
  assign add_out_valid = out_v;
  assign add_sum       = out_sum;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v   <= 1'b0;
      out_sum <= '0;
    end else if (add_valid && add_ready) begin
      out_v   <= 1'b1;
      out_sum <= add_a + add_b;
    end else if (add_out_ready && out_v) begin
      out_v <= 1'b0;
    end
  end

  // One cycle: observe handshakes due at the next edge, then advance to negedge.
  task automatic tick();
    logic [3:0] hs;
    rsp_t       e;
    #1;
    hs = req_valid & req_ready;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        e.id  = 2'(i);
        e.sum = a_arr[i] + b_arr[i];
        exp_q.push_back(e);
        grants.push_back(i);
      end
      if (rsp_valid[i] && rsp_ready[i]) begin
        e.id  = 2'(i);
        e.sum = rsp_sum;
        got_q.push_back(e);
      end
    end
    if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 || (busy && req_ready != 4'b0))
      viol++;
    @(posedge clk);
    #2;
    req_valid = req_valid & ~(hs & oneshot);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = 4'hF;
    add_rdy_en = 1'b1;
    oneshot    = 4'hF;
    exp_q.delete();
    got_q.delete();
    grants.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else n_pass++;
    n_checks++; if (add_valid !== 1'b0 || add_out_ready !== 1'b0)
      $display("FAIL reset_add got valid=%b out_ready=%b want 0 0", add_valid, add_out_ready); else n_pass++;
    n_checks++; if (grant_id !== 2'd0 || rsp_sum !== 32'd0 || add_a !== 32'd0 || add_b !== 32'd0)
      $display("FAIL reset_regs got id=%0d sum=%h a=%h b=%h want zeros", grant_id, rsp_sum, add_a, add_b); else n_pass++;
  endtask

  task automatic test_single();
    int   w;
    rsp_t e, g;
    a_arr[2]  = 32'd5;
    b_arr[2]  = 32'd7;
    req_valid = 4'b0100;
    for (int k = 0; k < 10 && grants.size() == 0; k++) tick();
    n_checks++; if (grants.size() != 1) $display("FAIL single_grant got %0d grants want 1", grants.size()); else n_pass++;
    n_checks++; if (add_valid !== 1'b1 || add_a !== 32'd5 || add_b !== 32'd7)
      $display("FAIL single_issue got valid=%b a=%0d b=%0d want 1 5 7", add_valid, add_a, add_b); else n_pass++;
    tick();
    n_checks++; if (add_out_valid !== 1'b1 || add_out_ready !== 1'b1)
      $display("FAIL single_wait got out_valid=%b out_ready=%b want 1 1", add_out_valid, add_out_ready); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 4'b0100 || rsp_sum !== 32'd12 || grant_id !== 2'd2)
      $display("FAIL single_resp got valid=%b sum=%0d id=%0d want 0100 12 2", rsp_valid, rsp_sum, grant_id); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle got busy=%b want 0", busy); else n_pass++;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 80) begin tick(); w++; end
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL single_count got %0d responses want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL single_sb got id=%0d sum=%h want id=%0d sum=%h", g.id, g.sum, e.id, e.sum); else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_contention();
    int   order [5] = '{0, 1, 2, 3, 0};
    int   w;
    rsp_t e, g;
    do_reset();
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'(i); b_arr[i] = 32'd100; end
    oneshot   = 4'h0;
    viol      = 0;
    req_valid = 4'hF;
    for (int k = 0; k < 60 && got_q.size() < 5; k++) tick();
    req_valid = '0;
    oneshot   = 4'hF;
    n_checks++; if (grants.size() != 5) $display("FAIL cont_grants got %0d grants want 5", grants.size()); else n_pass++;
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      n_checks++; if (grants[k] != order[k]) $display("FAIL cont_order[%0d] got %0d want %0d", k, grants[k], order[k]); else n_pass++;
    end
    for (int k = 0; k < 5 && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k].sum !== 32'(100 + order[k]))
        $display("FAIL cont_sum[%0d] got %0d want %0d", k, got_q[k].sum, 100 + order[k]); else n_pass++;
    end
    n_checks++; if (viol != 0) $display("FAIL cont_overlap got %0d violations want 0", viol); else n_pass++;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 80) begin tick(); w++; end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL cont_sb got id=%0d sum=%h want id=%0d sum=%h", g.id, g.sum, e.id, e.sum); else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    int   gbase, w;
    rsp_t e, g;
    a_arr[1]   = 32'hFFFF_FFFF;
    b_arr[1]   = 32'd2;
    add_rdy_en = 1'b0;
    gbase      = grants.size();
    req_valid  = 4'b0010;
    for (int k = 0; k < 10 && grants.size() == gbase; k++) tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (add_valid !== 1'b1 || add_a !== 32'hFFFF_FFFF || add_b !== 32'd2)
        $display("FAIL bp_hold[%0d] got valid=%b a=%h b=%h want 1 ffffffff 00000002", k, add_valid, add_a, add_b); else n_pass++;
      tick();
    end
    add_rdy_en = 1'b1;
    w = 0;
    while ((got_q.size() < exp_q.size() || exp_q.size() == 0) && w < 80) begin tick(); w++; end
    n_checks++; if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL bp_count got %0d responses %0d grants want 1 1", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e || g.sum !== 32'h1)
        $display("FAIL bp_sb got id=%0d sum=%h want id=%0d sum=%h", g.id, g.sum, e.id, e.sum); else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_sink_stall();
    int   gbase, w;
    rsp_t e, g;
    do_reset();
    viol      = 0;
    a_arr[1]  = 32'd10; b_arr[1] = 32'd20;
    a_arr[0]  = 32'd1;  b_arr[0] = 32'd1;
    a_arr[2]  = 32'd2;  b_arr[2] = 32'd2;
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    for (int k = 0; k < 20 && rsp_valid[1] !== 1'b1; k++) tick();
    req_valid = req_valid | 4'b0101;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (rsp_valid !== 4'b0010 || rsp_sum !== 32'd30 || req_ready !== 4'b0)
        $display("FAIL stall_hold[%0d] got rsp_valid=%b sum=%0d req_ready=%b want 0010 30 0000", k, rsp_valid, rsp_sum, req_ready); else n_pass++;
      tick();
    end
    rsp_ready = 4'hF;
    gbase     = grants.size();
    for (int k = 0; k < 10 && grants.size() == gbase; k++) tick();
    n_checks++; if (grants.size() <= gbase || grants[gbase] != 2)
      $display("FAIL stall_next got %0d want requester 2", (grants.size() > gbase) ? grants[gbase] : -1); else n_pass++;
    w = 0;
    while ((got_q.size() < exp_q.size() || exp_q.size() < 3) && w < 80) begin tick(); w++; end
    n_checks++; if (got_q.size() != 3 || exp_q.size() != 3)
      $display("FAIL stall_count got %0d responses %0d grants want 3 3", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL stall_sb got id=%0d sum=%h want id=%0d sum=%h", g.id, g.sum, e.id, e.sum); else n_pass++;
    end
    n_checks++; if (viol != 0) $display("FAIL stall_overlap got %0d violations want 0", viol); else n_pass++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_async_reset();
    int   gbase, w;
    rsp_t e, g;
    a_arr[3]  = 32'd40; b_arr[3] = 32'd2;
    a_arr[0]  = 32'd7;  b_arr[0] = 32'd8;
    req_valid = 4'b1000;
    for (int k = 0; k < 20 && add_out_ready !== 1'b1; k++) tick();
    #1 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0 || add_valid !== 1'b0 || add_out_ready !== 1'b0)
      $display("FAIL areset_now got busy=%b rsp_valid=%b add_valid=%b out_ready=%b want 0 0000 0 0",
               busy, rsp_valid, add_valid, add_out_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    gbase     = grants.size();
    req_valid = 4'b1001;
    for (int k = 0; k < 10 && grants.size() == gbase; k++) tick();
    n_checks++; if (grants.size() <= gbase || grants[gbase] != 0)
      $display("FAIL areset_first got %0d want requester 0", (grants.size() > gbase) ? grants[gbase] : -1); else n_pass++;
    w = 0;
    while ((got_q.size() < exp_q.size() || exp_q.size() < 2) && w < 80) begin tick(); w++; end
    n_checks++; if (got_q.size() != 2 || exp_q.size() != 2)
      $display("FAIL areset_count got %0d responses %0d grants want 2 2", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL areset_sb got id=%0d sum=%h want id=%0d sum=%h", g.id, g.sum, e.id, e.sum); else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef ADDER_RR_ARB_PRIO0_EN
  task automatic test_prio0();
    int gbase;
    do_reset();
    a_arr[0] = 32'd1; b_arr[0] = 32'd2;
    a_arr[3] = 32'd3; b_arr[3] = 32'd4;
    oneshot   = 4'h0;
    req_valid = 4'b1001;
    for (int k = 0; k < 60 && got_q.size() < 3; k++) tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (k >= grants.size() || grants[k] != 0)
        $display("FAIL prio_win[%0d] got %0d want 0", k, (k < grants.size()) ? grants[k] : -1); else n_pass++;
    end
    gbase = grants.size();
    for (int k = 0; k < 10 && grants.size() == gbase; k++) tick();
    req_valid = '0;
    oneshot   = 4'hF;
    n_checks++; if (grants.size() <= gbase || grants[gbase] != 3)
      $display("FAIL prio_drop got %0d want 3", (grants.size() > gbase) ? grants[gbase] : -1); else n_pass++;
    for (int k = 0; k < 20; k++) tick();
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    viol       = 0;
    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = 4'hF;
    add_rdy_en = 1'b1;
    oneshot    = 4'hF;
    for (int i = 0; i < 4; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sink_stall();
    test_async_reset();
`ifdef ADDER_RR_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one latency-insensitive 32-bit adder (valid/ready operand port, valid/ready result port, one transaction in flight) among N_REQ requesters.
- Accepts one operand pair at a time from the round-robin winner, issues it to the adder, captures the result and returns it to that requester over its response handshake.
- Sits between client blocks and the single adder instance.

Parameters:
- N_REQ, 4, number of requesters (legal range 1..16).
- DATA_W, 32, operand/result width; must match the adder width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  N_REQ*DATA_W  operand A per requester; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  N_REQ*DATA_W  operand B per requester, same packing as req_a.
- req_valid  in  N_REQ  operand valid per requester.
- req_ready  out  N_REQ  one-hot or zero; accept strobe to the winner.
- rsp_sum  out  DATA_W  result, shared bus, meaningful only while rsp_valid is nonzero.
- rsp_valid  out  N_REQ  one-hot or zero; result valid to the owning requester.
- rsp_ready  in  N_REQ  response accept per requester.
- add_a  out  DATA_W  operand A to the adder.
- add_b  out  DATA_W  operand B to the adder.
- add_valid  out  1  operand valid to the adder.
- add_ready  in  1  adder operand ready.
- add_sum  in  DATA_W  adder result.
- add_out_valid  in  1  adder result valid.
- add_out_ready  out  1  result accept to the adder.
- grant_id  out  $clog2(N_REQ) (minimum 1)  index of the current owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, grant_id=0, operand regs=0, sum reg=0. All outputs 0: req_ready, rsp_valid, add_valid, add_out_ready, busy.
- FSM states: IDLE, ISSUE, WAIT_RES, RESP.
- IDLE
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits 0.
  - On that handshake, latch req_a/req_b slices and grant_id=winner, then go to ISSUE.
  - No req_valid set: remain in IDLE; all req_ready=0.
- ISSUE
  - add_valid=1; add_a/add_b driven from the operand regs.
  - Go to WAIT_RES on add_ready=1; otherwise hold with operands stable.
- WAIT_RES
  - add_out_ready=1.
  - On add_out_valid=1, latch add_sum into the sum reg and go to RESP.
- RESP
  - rsp_valid[grant_id]=1; rsp_sum = sum reg.
  - On rsp_ready[grant_id]=1: rr_ptr = grant_id+1, wrapping N_REQ-1 to 0; then go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- add_out_valid in IDLE, ISSUE or RESP is ignored, because add_out_ready=0 in those states.
- Only one transaction is outstanding at any time. req_ready is 0 in every state except IDLE.
- Latency with zero-wait adder and sink:
  - req handshake at cycle 0;
  - add_valid/add_ready handshake at cycle 1;
  - add_out_valid at cycle 2;
  - rsp_valid at cycle 3.
  - Peak throughput is one operation per 4 cycles.
- Arithmetic: the block does not modify data; sums are modulo 2^DATA_W as produced by the adder.
- Outputs within the handshake discipline:
  - rsp_sum and grant_id are stable while rsp_valid is held.
  - add_a/add_b are stable while add_valid is held.
- N_REQ=1: the pointer stays 0; behaviour is otherwise identical.
- Reset asserted mid-operation clears all state immediately, and an in-flight result is discarded. The adder shares the system reset and clears at the same time.

Optional Feature:
- Macro ADDER_RR_ARB_PRIO0_EN.
  - Defined: requester 0 has strict priority in IDLE; it wins whenever req_valid[0]=1. Round-robin among requesters 1..N_REQ-1 applies only when req_valid[0]=0, and rr_ptr advances only on non-zero grants.
  - Not defined: pure round-robin over all requesters as above.

Test Plan:
- Single request: after reset, req 2 sends a=5, b=7 with all readies high. Expect rsp_valid=4'b0100, rsp_sum=12 at cycle 3 after the req handshake, then busy=0.
- Contention: all 4 requesters hold valid with a=i, b=100 throughout. Expect grant order 0,1,2,3,0 with sums 100,101,102,103,100. Expect no overlap of req_ready and no second grant before each response is accepted.
- Adder backpressure: add_ready=0 for 5 cycles. Expect add_valid held high with stable add_a/add_b, then the flow completes; sum 0xFFFFFFFF+2=0x00000001 (wraparound).
- Sink stall: rsp_ready[1]=0 for 6 cycles. Expect rsp_valid[1] and rsp_sum held and req_ready all 0 during the stall. After release, the next grant is requester 2.
- Async reset: assert rst in WAIT_RES between clock edges. Expect busy, rsp_valid, add_valid and add_out_ready at 0 immediately. After release, the first grant goes to requester 0.
- With ADDER_RR_ARB_PRIO0_EN: requesters 0 and 3 are continuously valid. Expect requester 0 granted every transaction. When requester 0 drops, requester 3 is granted.
